// File: rtl/digital_tube_pkg.sv
// Shared types and constants for the stopwatch master and the display controller's
// Avalon-MM register map.
package digital_tube_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned TIME_W  = 24;

  localparam logic              ADDR_ENABLE = 1'b0;
  localparam logic              ADDR_NUMBER = 1'b1;
  localparam logic [DATA_W-1:0] ENABLE_WORD = 32'h1;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {INIT_EN, IDLE, WR_NUM} wr_state_e;

  typedef struct packed {
    logic              address;
    logic [DATA_W-1:0] writedata;
  } avm_cmd_t;

  // Number register payload: six BCD digits in the low 24 bits.
  function automatic avm_cmd_t number_cmd(input logic [TIME_W-1:0] t);
    return '{address: ADDR_NUMBER, writedata: {8'h00, t}};
  endfunction

endpackage

// File: rtl/digital_tube_stopwatch_master_if.sv
// Avalon-MM write-only link between the stopwatch master and the display controller.
interface digital_tube_stopwatch_master_if;
  import digital_tube_pkg::*;

  logic              avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;

  modport master (output avm_address, avm_write, avm_writedata, input avm_waitrequest);
  modport slave  (input avm_address, avm_write, avm_writedata, output avm_waitrequest);

endinterface

// File: rtl/digital_tube_stopwatch_master_bcd_digit_counter.sv
// One BCD digit that counts 0..MAX and produces a carry when it rolls over.
module bcd_digit_counter
  import digital_tube_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  assign carry = inc && (digit == DIGIT_W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? '0 : digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/digital_tube_stopwatch_master.sv
// MM:SS.cc stopwatch that enables the display once, then pushes each new time value
// to the display number register, coalescing updates that arrive while a write stalls.
module digital_tube_stopwatch_master
  import digital_tube_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_stop,
  input  logic                   clear,
  digital_tube_stopwatch_master_if.master avm,
  output logic                   running,
  output logic [TIME_W-1:0]      time_bcd
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned DIV_W    = $clog2(TICK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic             c_cs0, c_cs1, c_s0, c_s1, c_m0, wrap_unused;

  wr_state_e state_q, state_d;
  logic      write_q, write_d;
  avm_cmd_t  cmd_q, cmd_d;
  logic      dirty_q, dirty_d;
  logic      launch_c;
  logic      accept_c;

  assign tick_c = running && (div_cnt == DIV_W'(TICK_DIV - 1));

  // Run flag and tick divider; the divider only advances while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      div_cnt <= '0;
    end else begin
      running <= running ^ start_stop;
      if (clear) begin
        div_cnt <= '0;
      end else if (running) begin
        div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

  bcd_digit_counter #(.MAX(9)) u_cs0 (.clk(clk), .rst(rst), .clr(clear), .inc(tick_c),
                                      .digit(time_bcd[3:0]),   .carry(c_cs0));
  bcd_digit_counter #(.MAX(9)) u_cs1 (.clk(clk), .rst(rst), .clr(clear), .inc(c_cs0),
                                      .digit(time_bcd[7:4]),   .carry(c_cs1));
  bcd_digit_counter #(.MAX(9)) u_s0  (.clk(clk), .rst(rst), .clr(clear), .inc(c_cs1),
                                      .digit(time_bcd[11:8]),  .carry(c_s0));
  bcd_digit_counter #(.MAX(5)) u_s1  (.clk(clk), .rst(rst), .clr(clear), .inc(c_s0),
                                      .digit(time_bcd[15:12]), .carry(c_s1));
  bcd_digit_counter #(.MAX(9)) u_m0  (.clk(clk), .rst(rst), .clr(clear), .inc(c_s1),
                                      .digit(time_bcd[19:16]), .carry(c_m0));
  bcd_digit_counter #(.MAX(5)) u_m1  (.clk(clk), .rst(rst), .clr(clear), .inc(c_m0),
                                      .digit(time_bcd[23:20]), .carry(wrap_unused));

  assign accept_c = write_q && !avm.avm_waitrequest;

  // Write FSM: the command register is only reloaded when a write is launched.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    cmd_d    = cmd_q;
    launch_c = 1'b0;
    unique case (state_q)
      INIT_EN: begin
        write_d = 1'b1;
        cmd_d   = '{address: ADDR_ENABLE, writedata: ENABLE_WORD};
        if (accept_c) begin
          state_d = IDLE;
          write_d = 1'b0;
        end
      end
      IDLE: begin
        if (dirty_q) begin
          state_d  = WR_NUM;
          write_d  = 1'b1;
          cmd_d    = number_cmd(time_bcd);
          launch_c = 1'b1;
        end
      end
      WR_NUM: begin
        if (accept_c) begin
          state_d = IDLE;
          write_d = 1'b0;
        end
      end
      default: begin
        state_d = INIT_EN;
        write_d = 1'b0;
      end
    endcase
    // A time change in the launch cycle is newer than the snapshot, so it wins.
    dirty_d = tick_c || clear || (dirty_q && !launch_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_EN;
      write_q <= 1'b0;
      cmd_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      cmd_q   <= cmd_d;
      dirty_q <= dirty_d;
    end
  end

  assign avm.avm_write     = write_q;
  assign avm.avm_address   = cmd_q.address;
  assign avm.avm_writedata = cmd_q.writedata;

endmodule

// File: doc/digital_tube_stopwatch_master.md
# digital_tube_stopwatch_master

Avalon-MM master that drives the seven-segment display controller's slave port. It contains a free-running stopwatch in BCD (MM:SS.cc, six digits) and writes each new value to the controller's number register, after enabling the display once out of reset. It sits between user start/stop/clear strobes and the controller's Avalon-MM slave interface.

## Interface
- CLK_FREQ, 25_000_000: clk frequency in Hz.
- TICK_HZ, 100: stopwatch resolution in Hz (centiseconds). TICK_DIV = CLK_FREQ/TICK_HZ must be an integer ≥ 2.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- start_stop  in  1  one-cycle pulse; toggles the run state.
- clear  in  1  one-cycle pulse; zeroes the time and the tick divider.
- avm_address  out  1  0 = display enable register, 1 = display number register.
- avm_write  out  1  write strobe, held until accepted.
- avm_writedata  out  32  write data. Enable write: 32'h1. Number write: {8'h00, time_bcd}.
- avm_waitrequest  in  1  slave stall; a write is accepted on the first rising edge with avm_write=1 and avm_waitrequest=0.
- running  out  1  current run state.
- time_bcd  out  24  [23:20] min tens, [19:16] min units, [15:12] sec tens, [11:8] sec units, [7:4] cs tens, [3:0] cs units.

## Operation
- **Reset values:** avm_write=0, avm_address=0, avm_writedata=0, running=0, time_bcd=0, divider=0, dirty=0, FSM=INIT_EN.
- **Tick divider:** counts 0..TICK_DIV-1 only while running=1. The tick is the cycle it equals TICK_DIV-1; the divider then wraps to 0. Stopping freezes the divider value, and it resumes from there.
- **BCD counter:** on a tick, increments. cs units carry at 9, cs tens carry at 9, sec units at 9, sec tens at 5, min units at 9, min tens at 5.
  - 59:59.99 wraps to 00:00.00. No overflow flag.
  - Digits never hold values above 9, or above 5 for the tens-of-sec and tens-of-min digits.
- **clear:** zeroes time_bcd and the divider on the next edge and sets dirty. It does not change running. clear in the same cycle as a tick: clear wins.
- **start_stop:** toggles running on the next edge. start_stop together with clear: both take effect.
- **dirty flag:** set on any change of time_bcd (tick or clear). Cleared when a number write is launched.
- **FSM states:**
  - INIT_EN: avm_address=0, avm_writedata=1, avm_write=1. Moves to IDLE on acceptance.
  - IDLE: avm_write=0. If dirty=1, moves to WR_NUM, loading avm_address=1 and avm_writedata={8'h00, time_bcd} at that edge (snapshot), and clears dirty.
  - WR_NUM: avm_write=1, address and data held stable while avm_waitrequest=1. On acceptance returns to IDLE.
- **Updates during a write:** an update while in WR_NUM sets dirty again. The next write carries the latest value, so intermediate values are coalesced rather than queued. Counting never stalls on avm_waitrequest.
- **Reset mid-write:** avm_write drops asynchronously and the FSM returns to INIT_EN. The enable write is reissued after rst deasserts.

## Timing
- The tick at edge N updates time_bcd at edge N and sets dirty.
- The FSM leaves IDLE at edge N+1. avm_write=1 with the new data is visible from N+1.
- With avm_waitrequest=0, acceptance occurs at edge N+2. Best-case latency from time update to accepted write is 2 cycles.
- Minimum spacing between number writes is 2 cycles (WR_NUM→IDLE→WR_NUM). No back-to-back accepted writes.
- The first enable write is asserted in the first cycle after rst deasserts. Number writes start only after the enable write is accepted. Ticks before then only set dirty.
- avm_address and avm_writedata change only on the edge that enters INIT_EN or WR_NUM.

## Structure
- **Package digital_tube_pkg:**
  - ADDR_ENABLE=1'b0, ADDR_NUMBER=1'b1.
  - ENABLE_WORD=32'h1.
  - FSM state enum {INIT_EN, IDLE, WR_NUM}.
  - 4-bit BCD digit typedef.
- **Sub-module bcd_digit_counter:** parameter MAX (9 or 5); inputs clk, rst, clr, inc; outputs digit[3:0] and carry (inc && digit==MAX). Six instances are chained by carry. The top level holds the divider, run flag, dirty flag and write FSM.

## Test plan
Bench uses CLK_FREQ=1000, TICK_HZ=100 (TICK_DIV=10).
- **Reset:** rst pulse, avm_waitrequest=0 → one write at address 0, data 32'h1, on the first edge after release. Then avm_write=0 and running=0.
- **Start and count:** start_stop pulse, 10 ticks (100 cycles) → time_bcd=24'h000010. Ten number writes at address 1 with data 0x000001..0x000010, each accepted 2 cycles after its update.
- **Wrap:** preload via 359999 ticks (or force the digits) to 24'h595999, one more tick → time_bcd=24'h000000 and a write of 32'h00000000.
- **Backpressure:** hold avm_waitrequest=1 for 25 cycles while running → address and data stay stable throughout. After release, the next write carries the latest value, for example 0x000003, with no intermediate values.
- **Clear with tick:** clear on the same cycle as a tick at 24'h000042 → time_bcd=0, divider=0, running unchanged. Then a write of 0.
- **Reset mid-write:** rst asserted while WR_NUM is stalled → avm_write=0 immediately, time_bcd=0, then the enable write is reissued.
